// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline sequencer.
// Register index width, sequencer states, NOP encoding and a match helper.
package arm_pipe_pkg;

  localparam int REG_IDX_W = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    WAIT      = 2'd1,
    BR_REPLAY = 2'd2
  } seq_state_t;

  function automatic logic src_hit(
    input logic [REG_IDX_W-1:0] src,
    input logic [REG_IDX_W-1:0] dest,
    input logic                 en
  );
    return en && (src == dest);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bundle between the stage datapath and the sequencer.
// master: datapath side (drives stage info); slave: sequencer side.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import arm_pipe_pkg::*;

  logic [REG_IDX_W-1:0] src1;
  logic [REG_IDX_W-1:0] src2;
  logic                 two_src;
  logic [REG_IDX_W-1:0] exe_dest;
  logic                 exe_wb_en;
  logic                 exe_mem_r_en;
  logic [REG_IDX_W-1:0] mem_dest;
  logic                 mem_wb_en;
  logic                 branch_taken;
  logic                 mem_access;
  logic                 mem_ready;

  logic                 if_freeze;
  logic                 if_flush;
  logic                 id_flush;
  logic                 pipe_freeze;
  logic                 mem_timeout;
  logic [CNT_W-1:0]     stall_cnt;
  logic [CNT_W-1:0]     flush_cnt;

  modport master (
    output src1, src2, two_src,
    output exe_dest, exe_wb_en, exe_mem_r_en,
    output mem_dest, mem_wb_en,
    output branch_taken, mem_access, mem_ready,
    input  if_freeze, if_flush, id_flush,
    input  pipe_freeze, mem_timeout,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  src1, src2, two_src,
    input  exe_dest, exe_wb_en, exe_mem_r_en,
    input  mem_dest, mem_wb_en,
    input  branch_taken, mem_access, mem_ready,
    output if_freeze, if_flush, id_flush,
    output pipe_freeze, mem_timeout,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// RAW hazard detector: ID sources against EXE/MEM destinations.
// Ports: src1/src2/two_src, exe_*/mem_* stage info -> hazard. Macro: FORWARDING_EN.
module hazard_detect
  import arm_pipe_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src1,
  input  logic [REG_IDX_W-1:0] src2,
  input  logic                 two_src,
  input  logic [REG_IDX_W-1:0] exe_dest,
  input  logic                 exe_wb_en,
  input  logic                 exe_mem_r_en,
  input  logic [REG_IDX_W-1:0] mem_dest,
  input  logic                 mem_wb_en,
  output logic                 hazard
);

`ifdef FORWARDING_EN
  // Forwarding covers ALU results; only a load in EXE cannot be bypassed.
  logic unused_fwd;
  assign unused_fwd = ^{exe_wb_en, mem_dest, mem_wb_en};

  always_comb begin
    hazard = src_hit(src1, exe_dest, exe_mem_r_en)
           | (two_src & src_hit(src2, exe_dest, exe_mem_r_en));
  end
`else
  logic unused_ld;
  assign unused_ld = exe_mem_r_en;

  always_comb begin
    hazard = src_hit(src1, exe_dest, exe_wb_en)
           | src_hit(src1, mem_dest, mem_wb_en)
           | (two_src & src_hit(src2, exe_dest, exe_wb_en))
           | (two_src & src_hit(src2, mem_dest, mem_wb_en));
  end
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: freeze/flush from hazards, EXE branches, SRAM waits.
// Ports: clk, rst (async high), bus (slave). Params MAX_WAIT, CNT_W. Macro: FORWARDING_EN.
module pipe_hazard_ctrl
  import arm_pipe_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int WC_W = $clog2(MAX_WAIT + 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic             br_pend;
  logic [WC_W-1:0]  wait_cnt;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  logic mem_stall;
  logic hazard;
  logic branch_now;
  logic ifz;
  logic ifl;
  logic idf;
  logic pfz;

  assign mem_stall = bus.mem_access & ~bus.mem_ready;

  hazard_detect u_hd (
    .src1         (bus.src1),
    .src2         (bus.src2),
    .two_src      (bus.two_src),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_r_en (bus.exe_mem_r_en),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .hazard       (hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    ifz        = 1'b0;
    ifl        = 1'b0;
    idf        = 1'b0;
    pfz        = 1'b0;
    branch_now = bus.branch_taken | (state == BR_REPLAY);

    if (mem_stall) begin
      pfz = 1'b1;
      ifz = 1'b1;
    end else if (branch_now) begin
      ifl = 1'b1;
      idf = 1'b1;
    end else if (hazard) begin
      ifz = 1'b1;
      idf = 1'b1;
    end

    unique case (state)
      RUN: begin
        if (mem_stall) state_nxt = WAIT;
      end
      WAIT: begin
        if (!mem_stall)
          state_nxt = br_pend ? BR_REPLAY : RUN;
      end
      BR_REPLAY: begin
        state_nxt = mem_stall ? WAIT : RUN;
      end
      default: state_nxt = RUN;
    endcase

    if (rst) begin
      ifz = 1'b0;
      ifl = 1'b0;
      idf = 1'b0;
      pfz = 1'b0;
    end
  end

  // A branch resolving under a stall is frozen in EXE; remember it
  // and replay the flush once the pipe moves again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      br_pend <= 1'b0;
    else if (mem_stall && bus.branch_taken)
      br_pend <= 1'b1;
    else if (state == BR_REPLAY && !mem_stall)
      br_pend <= 1'b0;
  end

  // Counts consecutive frozen cycles; the stall itself is never aborted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else if (mem_stall) begin
      if (wait_cnt != WC_W'(MAX_WAIT))
        wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WC_W'(MAX_WAIT - 1))
        timeout_q <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((ifz | pfz) && stall_q != '1)
        stall_q <= stall_q + 1'b1;
      if (ifl && flush_q != '1)
        flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.if_freeze   = ifz;
  assign bus.if_flush    = ifl;
  assign bus.id_flush    = idf;
  assign bus.pipe_freeze = pfz;
  assign bus.mem_timeout = timeout_q;
  assign bus.stall_cnt   = stall_q;
  assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with an expected-result queue.
// Steps drive one cycle each; expectations are popped at the negedge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        ifz;
    logic        ifl;
    logic        idf;
    logic        pf;
    logic        to;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   sc = 0;
  int   fc = 0;
  exp_t sb[$];

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipe_hazard_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.src1         = 4'd0;
    bus.src2         = 4'd0;
    bus.two_src      = 1'b0;
    bus.exe_dest     = 4'd0;
    bus.exe_wb_en    = 1'b0;
    bus.exe_mem_r_en = 1'b0;
    bus.mem_dest     = 4'd0;
    bus.mem_wb_en    = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_access   = 1'b0;
    bus.mem_ready    = 1'b0;
  endtask

  task automatic compare(input string tag);
    exp_t e;
    exp_t g;
    e = sb.pop_front();
    g = {bus.if_freeze, bus.if_flush, bus.id_flush, bus.pipe_freeze,
         bus.mem_timeout, bus.stall_cnt, bus.flush_cnt};
    tests++;
    assert (g === e) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h (ifz ifl idf pf to sc fc)", tag, g, e);
    end
  endtask

  // One cycle: expected controls for the driven inputs, counters as of now.
  task automatic chk(input string tag, input logic ifz, input logic ifl,
                     input logic idf, input logic pf, input logic to);
    sb.push_back({ifz, ifl, idf, pf, to, 32'(sc), 32'(fc)});
    if (!rst) begin
      if (ifz || pf) sc++;
      if (ifl) fc++;
    end
    @(negedge clk);
    compare(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    bus.src1 = 4'd3; bus.exe_dest = 4'd3; bus.exe_wb_en = 1'b1;
    chk("reset_quiet", 0, 0, 0, 0, 0);
    rst = 1'b0;

    idle(); bus.src1 = 4'd3; bus.exe_dest = 4'd3; bus.exe_wb_en = 1'b1;
    chk("t1_exe_raw", !FWD, 0, !FWD, 0, 0);
    idle();
    chk("t1_cnt", 0, 0, 0, 0, 0);
    idle(); bus.src1 = 4'd3; bus.exe_dest = 4'd3;
    chk("no_wb_en", 0, 0, 0, 0, 0);
    idle(); bus.src2 = 4'd7; bus.exe_dest = 4'd7; bus.exe_wb_en = 1'b1;
    chk("src2_unused", 0, 0, 0, 0, 0);
    bus.two_src = 1'b1;
    chk("src2_raw", !FWD, 0, !FWD, 0, 0);
    idle(); bus.src1 = 4'd0; bus.mem_dest = 4'd0; bus.mem_wb_en = 1'b1;
    chk("r0_mem_raw", !FWD, 0, !FWD, 0, 0);

    idle(); bus.src1 = 4'd5; bus.mem_dest = 4'd5; bus.mem_wb_en = 1'b1;
    chk("t2_mem_fwd", !FWD, 0, !FWD, 0, 0);
    idle(); bus.src1 = 4'd5; bus.exe_dest = 4'd5;
    bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1;
    chk("t2_load_use", 1, 0, 1, 0, 0);
    idle();
    chk("t2_after", 0, 0, 0, 0, 0);

    idle(); bus.src1 = 4'd2; bus.exe_dest = 4'd2; bus.exe_wb_en = 1'b1;
    bus.exe_mem_r_en = 1'b1; bus.branch_taken = 1'b1;
    chk("t3_br_haz", 0, 1, 1, 0, 0);
    idle();
    chk("t3_cnt", 0, 0, 0, 0, 0);

    idle(); bus.mem_access = 1'b1;
    chk("t4_stall1", 1, 0, 0, 1, 0);
    bus.branch_taken = 1'b1;
    chk("t4_stall2_br", 1, 0, 0, 1, 0);
    bus.branch_taken = 1'b0;
    chk("t4_stall3", 1, 0, 0, 1, 0);
    bus.mem_ready = 1'b1;
    chk("t4_ready", 0, 0, 0, 0, 0);
    idle(); bus.src1 = 4'd9; bus.exe_dest = 4'd9; bus.exe_wb_en = 1'b1;
    bus.exe_mem_r_en = 1'b1;
    chk("t4_replay", 0, 1, 1, 0, 0);
    idle();
    chk("t4_run", 0, 0, 0, 0, 0);
    chk("t4_no_2nd", 0, 0, 0, 0, 0);

    for (int i = 1; i <= 20; i++) begin
      idle(); bus.mem_access = 1'b1;
      chk($sformatf("t5_stall%0d", i), 1, 0, 0, 1, i >= 17);
    end
    bus.mem_ready = 1'b1;
    chk("t5_ready", 0, 0, 0, 0, 1);
    idle();
    chk("t5_sticky", 0, 0, 0, 0, 1);

    idle(); bus.mem_access = 1'b1; bus.branch_taken = 1'b1;
    chk("t6_stall_br", 1, 0, 0, 1, 1);
    idle(); bus.mem_access = 1'b1;
    chk("t6_wait", 1, 0, 0, 1, 1);
    idle(); bus.mem_access = 1'b1;
    #2 rst = 1'b1;
    #1;
    sc = 0;
    fc = 0;
    sb.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
    compare("t6_rst_async");
    @(posedge clk);
    #1;
    idle();
    rst = 1'b0;
    chk("t6_no_replay", 0, 0, 0, 0, 0);
    chk("t6_no_replay2", 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
